// File: rtl/button_step_gen_pkg.sv
// Shared encodings and default timing values for the button step generator.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } btn_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 100000;
    localparam int unsigned REPEAT_DELAY_DEF    = 50000000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 10000000;

endpackage

// File: rtl/button_step_gen_if.sv
// Button-side signal bundle: raw press input and the debounced/pulse outputs.
interface button_step_gen_if;
    logic       p;
    logic       level;
    logic       step;
    logic       rel;
    logic [7:0] presses;

    modport master (output p, input level, step, rel, presses);
    modport slave  (input p, output level, step, rel, presses);
endinterface

// File: rtl/button_step_gen_sync.sv
// Two-flop synchronizer for a single asynchronous bit; both flops clear on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/button_step_gen.sv
// Debounced push-button with step/release pulses and a wrapping press counter.
// Optional auto-repeat while held is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_step_gen
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    button_step_gen_if.slave   btn
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    // The state change happens on the edge the counter would reach DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 2);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_step_gen: invalid timing parameters");
    end

    logic          sp;
    btn_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          step_q;
    logic          rel_q;
    logic [7:0]    presses_q;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = $clog2(REP_MAX + 1);
    logic [RW-1:0] rep_cnt_q;
    logic          rep_first_q;
    logic [RW-1:0] rep_target_d;
    assign rep_target_d = rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
`endif

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn.p),
        .q_o (sp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            step_q    <= 1'b0;
            rel_q     <= 1'b0;
            presses_q <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            step_q <= 1'b0;
            rel_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sp) begin
                        state_q <= ARMING;
                        cnt_q   <= '0;
                    end
                end
                ARMING: begin
                    if (!sp) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q   <= HELD;
                        cnt_q     <= '0;
                        level_q   <= 1'b1;
                        step_q    <= 1'b1;
                        presses_q <= presses_q + 8'd1;
`ifdef BUTTON_AUTOREPEAT_EN
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!sp) begin
                        state_q <= RELEASING;
                        cnt_q   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b1;
                    end else if (rep_cnt_q + RW'(1) == rep_target_d) begin
                        step_q      <= 1'b1;
                        presses_q   <= presses_q + 8'd1;
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b0;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + RW'(1);
`endif
                    end
                end
                RELEASING: begin
                    // A bounce back to 1 returns to HELD silently and restarts the repeat delay.
                    if (sp) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b1;
`endif
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        rel_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn.level   = level_q;
    assign btn.step    = step_q;
    assign btn.rel     = rel_q;
    assign btn.presses = presses_q;
endmodule

// File: doc/button_step_gen.md
BUTTON_STEP_GEN -- requirements
Module: button_step_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100000: consecutive stable cycles required to accept a level change (minimum 2).
REQ-002 Parameter REPEAT_DELAY, default 50000000: cycles held before first auto-repeat step (used only with AUTOREPEAT_EN).
REQ-003 Parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat steps (used only with AUTOREPEAT_EN).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 p  input  1  raw push-button, asynchronous, bouncing, active-high.
REQ-007 level  output  1  debounced button level.
REQ-008 step  output  1  one-cycle pulse per accepted press (and per auto-repeat).
REQ-009 rel  output  1  one-cycle pulse per accepted release.
REQ-010 presses  output  8  count of step pulses, wraps 255->0.

Function
REQ-011 p SHALL pass a 2-flop synchronizer before any other use; the synchronized value is sp.
REQ-012 FSM states SHALL be IDLE (level=0), ARMING, HELD (level=1), RELEASING.
REQ-013 IDLE: sp=1 -> ARMING with debounce counter cleared to 0.
REQ-014 ARMING: counter increments each cycle sp=1; sp=0 -> IDLE with counter cleared; when counter reaches DEBOUNCE_CYCLES-1 with sp=1 -> HELD, level=1 and step=1 on the entry edge.
REQ-015 HELD: sp=0 -> RELEASING with counter cleared; sp=1 holds.
REQ-016 RELEASING: counter increments each cycle sp=0; sp=1 -> HELD with no pulse; counter reaches DEBOUNCE_CYCLES-1 -> IDLE, level=0, rel=1 on the entry edge.
REQ-017 Latency from clean p edge to step/rel pulse SHALL be exactly 2+DEBOUNCE_CYCLES cycles.
REQ-018 Any bounce shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no level change.
REQ-019 step and rel SHALL never be high together and SHALL each be high for exactly one cycle per event.
REQ-020 presses SHALL increment by 1 on every cycle step=1, modulo 256.
REQ-021 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES) bits and SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-022 rst=1 SHALL force state IDLE, level=0, step=0, rel=0, presses=0, all counters 0, synchronizer flops 0 on the next edge.
REQ-023 rst asserted mid-ARMING, mid-HELD or mid-repeat SHALL abort without emitting step or rel; after release a still-pressed button SHALL require a full new debounce.

Configuration
REQ-024 Macro BUTTON_AUTOREPEAT_EN SHALL gate auto-repeat logic.
REQ-025 With BUTTON_AUTOREPEAT_EN defined: in HELD a repeat counter starts at HELD entry; first extra step after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles while HELD; leaving HELD (including to RELEASING) clears it, and HELD re-entry from RELEASING restarts the REPEAT_DELAY interval.
REQ-026 Without the macro: no repeat counter synthesized; exactly one step per press regardless of hold duration.

Structure
REQ-027 Shared package button_pkg SHALL hold FSM state encodings (2-bit) and default values of DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD.
REQ-028 Synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset to 0); the FSM and counters stay in button_step_gen.

Verification (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 p 0->1 held 20 cycles -> step high exactly 1 cycle, 6 cycles after p edge; level=1; presses=1.
REQ-030 p bouncing 1,0,1,0 each 2 cycles then stable 1 -> single step 6 cycles after the last rising edge; no rel.
REQ-031 p 1->0 after HELD, with 3-cycle glitch back to 1 -> no rel during glitch; rel 6 cycles after final fall; level=0.
REQ-032 256 clean presses -> presses reads 0 after the 256th step.
REQ-033 rst pulsed 1 cycle in ARMING with p held 1 -> no step during or at reset; step 6 cycles after rst deasserts.
REQ-034 With BUTTON_AUTOREPEAT_EN, p held 25 cycles after HELD entry -> steps at HELD entry +10, +13, +16, +19, +22, +25 relative to entry (7 total incl. entry); without macro -> 1 step.
